// File: rtl/sctag_pcx_rptr_pkg.sv
// Shared constants and sizing helpers for the PCX->SCTAG pipelined repeater.
package sctag_pcx_rptr_pkg;

  localparam int PCX_WIDTH_DEF = 124;
  localparam int MAX_STAGES    = 4;

  function automatic int rptr_depth(input int stages);
    return 2 * stages + 4;
  endfunction

  // A stall seen at this fill level still leaves room for everything already in flight.
  function automatic int rptr_stall_thr(input int stages);
    return rptr_depth(stages) - 2 * stages - 1;
  endfunction

endpackage

// File: rtl/sctag_pcx_rptr_skid.sv
// Generic DEPTH x W skid FIFO with occupancy count, full/empty and sticky overflow.
module sctag_pcx_rptr_skid
  import sctag_pcx_rptr_pkg::*;
#(
  parameter int W     = PCX_WIDTH_DEF + 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovfl
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovfl   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
      if (push && !do_push) ovfl <= 1'b1;
    end
  end

endmodule

// File: rtl/sctag_pcx_rptr_pipe.sv
// PCX->SCTAG repeater: STAGES-deep forward and stall-return pipes feeding an output skid FIFO.
// Optional even parity on buffered packets is enabled by defining SCTAG_PCX_RPTR_PAR_EN.
module sctag_pcx_rptr_pipe
  import sctag_pcx_rptr_pkg::*;
#(
  parameter int WIDTH  = PCX_WIDTH_DEF,
  parameter int STAGES = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             pcx_sctag_data_rdy_px1,
  input  logic             pcx_sctag_atm_px1,
  input  logic [WIDTH-1:0] pcx_sctag_data_px2,
  input  logic             sctag_pcx_stall_pq,
  output logic             pcx_sctag_data_rdy_buf,
  output logic             pcx_sctag_atm_buf,
  output logic [WIDTH-1:0] pcx_sctag_data_buf,
  output logic             sctag_pcx_stall_pq_buf,
  output logic             rptr_ovfl
`ifdef SCTAG_PCX_RPTR_PAR_EN
  ,
  output logic             rptr_par_err
`endif
);

  localparam int DEPTH     = rptr_depth(STAGES);
  localparam int STALL_THR = rptr_stall_thr(STAGES);
  localparam int CNT_W     = $clog2(DEPTH + 1);
`ifdef SCTAG_PCX_RPTR_PAR_EN
  localparam int PAY_W     = WIDTH + 2;
`else
  localparam int PAY_W     = WIDTH + 1;
`endif

  logic             vld_p   [STAGES];
  logic [PAY_W-1:0] pay_p   [STAGES];
  logic             stall_p [STAGES];
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             skid_full;
  logic             skid_empty;
  logic             stall_raw;

`ifdef SCTAG_PCX_RPTR_PAR_EN
  assign pay_in = {^{pcx_sctag_atm_px1, pcx_sctag_data_px2}, pcx_sctag_atm_px1, pcx_sctag_data_px2};
`else
  assign pay_in = {pcx_sctag_atm_px1, pcx_sctag_data_px2};
`endif

  // Forward stages: valid every cycle, payload only alongside a valid.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s] <= 1'b0;
        pay_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= pcx_sctag_data_rdy_px1;
      if (pcx_sctag_data_rdy_px1) pay_p[0] <= pay_in;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) pay_p[s] <= pay_p[s-1];
      end
    end
  end

  sctag_pcx_rptr_skid #(
    .W     (PAY_W),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (arst_l),
    .push      (vld_p[STAGES-1]),
    .push_data (pay_p[STAGES-1]),
    .pop       (pcx_sctag_data_rdy_buf),
    .head      (head),
    .count     (count),
    .full      (skid_full),
    .empty     (skid_empty),
    .ovfl      (rptr_ovfl)
  );

  assign pcx_sctag_data_rdy_buf = ~skid_empty & ~sctag_pcx_stall_pq;
  assign pcx_sctag_atm_buf      = head[WIDTH];
  assign pcx_sctag_data_buf     = head[WIDTH-1:0];

  // Stall return stages.
  assign stall_raw = (count >= CNT_W'(STALL_THR));

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int s = 0; s < STAGES; s++) stall_p[s] <= 1'b0;
    end else begin
      stall_p[0] <= stall_raw;
      for (int s = 1; s < STAGES; s++) stall_p[s] <= stall_p[s-1];
    end
  end

  assign sctag_pcx_stall_pq_buf = stall_p[STAGES-1];

`ifdef SCTAG_PCX_RPTR_PAR_EN
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l)                                rptr_par_err <= 1'b0;
    else if (pcx_sctag_data_rdy_buf && (^head)) rptr_par_err <= 1'b1;
  end
`endif

  // A PCX that ignores the returned stall loses the packet here.
  always @(posedge rclk) begin
    if (arst_l) begin
      assert (!(vld_p[STAGES-1] && skid_full && !pcx_sctag_data_rdy_buf))
        else $warning("sctag_pcx_rptr_pipe: skid write while full, packet dropped");
    end
  end

endmodule

// File: tb/tb_sctag_pcx_rptr_pipe.sv
// Directed bench for sctag_pcx_rptr_pipe (WIDTH=124, STAGES=2, DEPTH=8).
module tb_sctag_pcx_rptr_pipe;

  localparam int W = 124;

  logic         rclk;
  logic         arst_l;
  logic         px_rdy;
  logic         px_atm;
  logic [W-1:0] px_data;
  logic         sc_stall;
  logic         buf_rdy;
  logic         buf_atm;
  logic [W-1:0] buf_data;
  logic         buf_stall;
  logic         ovfl;
`ifdef SCTAG_PCX_RPTR_PAR_EN
  logic         par_err;
`endif

  sctag_pcx_rptr_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .rclk                   (rclk),
    .arst_l                 (arst_l),
    .pcx_sctag_data_rdy_px1 (px_rdy),
    .pcx_sctag_atm_px1      (px_atm),
    .pcx_sctag_data_px2     (px_data),
    .sctag_pcx_stall_pq     (sc_stall),
    .pcx_sctag_data_rdy_buf (buf_rdy),
    .pcx_sctag_atm_buf      (buf_atm),
    .pcx_sctag_data_buf     (buf_data),
    .sctag_pcx_stall_pq_buf (buf_stall),
    .rptr_ovfl              (ovfl)
`ifdef SCTAG_PCX_RPTR_PAR_EN
    ,
    .rptr_par_err           (par_err)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int         errors = 0;
  int         checks = 0;
  int         cyc_n  = 0;
  int         n_out  = 0;
  bit         lat_en = 0;
  bit         nostall_en = 0;
  bit         sb_en = 1;
  bit         last_sent = 0;
  logic [W:0] exp_q [$];
  int         in_q  [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, then check what the next rising edge will act on.
  task automatic cyc(input logic r, input logic a, input logic [W-1:0] d, input logic s,
                     input bit track, input bit honor);
    int lat;
    @(negedge rclk);
    if (honor && buf_stall) r = 1'b0;
    px_rdy = r; px_atm = a; px_data = d; sc_stall = s;
    last_sent = r;
    if (r && track) begin
      exp_q.push_back({a, d});
      in_q.push_back(cyc_n);
    end
    #1;
    if (buf_rdy && sb_en) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
      else begin
        chk("out_pkt", {buf_atm, buf_data}, exp_q.pop_front());
        lat = in_q.pop_front();
        if (lat_en) chk("latency", cyc_n - lat, 3);
      end
    end
    if (nostall_en) chk("stall_buf_idle", buf_stall, 1'b0);
    cyc_n++;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, s, 1'b0, 1'b0);
  endtask

  initial begin
    int first_k;
    int sent;
    int out0;
    px_rdy = 0; px_atm = 0; px_data = '0; sc_stall = 0;
    arst_l = 1'b1;
    #1 arst_l = 1'b0;
    #1;
    chk("rst_rdy",   buf_rdy,   1'b0);
    chk("rst_atm",   buf_atm,   1'b0);
    chk("rst_data",  buf_data,  '0);
    chk("rst_stall", buf_stall, 1'b0);
    chk("rst_ovfl",  ovfl,      1'b0);
`ifdef SCTAG_PCX_RPTR_PAR_EN
    chk("rst_par_err", par_err, 1'b0);
`endif
    #10 arst_l = 1'b1;

    // Single packet at cycle 10: output 3 cycles later, then empty again.
    lat_en = 1; nostall_en = 1;
    idle(1, 1'b0);
    chk("post_rst_rdy",  buf_rdy,  1'b0);
    chk("post_rst_data", buf_data, '0);
    while (cyc_n < 10) idle(1, 1'b0);
    cyc(1'b1, 1'b0, 124'h0A5, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0); chk("single_lat1", buf_rdy, 1'b0);
    idle(1, 1'b0); chk("single_lat2", buf_rdy, 1'b0);
    idle(1, 1'b0); chk("single_rdy",  buf_rdy, 1'b1);
    chk("single_data", buf_data, 124'h0A5);
    idle(1, 1'b0); chk("single_empty", buf_rdy, 1'b0);

    // 20-packet back-to-back stream, no stall.
    out0 = n_out;
    for (int i = 0; i < 20; i++)
      cyc(1'b1, i[0], 124'h1000 + W'(i), 1'b0, 1'b1, 1'b0);
    idle(5, 1'b0);
    chk("stream_count", n_out - out0, 20);
    chk("stream_drained", exp_q.size(), 0);
    lat_en = 0; nostall_en = 0;

    // Stall held while a well-behaved PCX streams.
    first_k = -1; sent = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1, 1'b0, 124'h4000 + W'(k), 1'b1, 1'b1, 1'b1);
      sent += int'(last_sent);
      if (buf_stall && first_k < 0) first_k = k;
    end
    chk("honor_stall_rise", first_k, 7);
    chk("honor_sent", sent, 7);
    chk("honor_ovfl", ovfl, 1'b0);
    out0 = n_out;
    idle(12, 1'b0);
    chk("honor_drain_count", n_out - out0, 7);
    chk("honor_drained", exp_q.size(), 0);
    chk("honor_stall_fall", buf_stall, 1'b0);

    // PCX ignores stall: 9 packets into an 8-entry FIFO while SCTAG stalls 12 cycles.
    for (int k = 0; k < 12; k++) begin
      cyc(k < 9, 1'b0, 124'h2000 + W'(k), 1'b1, k < 8, 1'b0);
      if (k == 10) chk("ovfl_before", ovfl, 1'b0);
      if (k == 11) begin
        chk("ovfl_after", ovfl, 1'b1);
        chk("ovfl_head_kept", buf_data, 124'h2000);
      end
    end
    out0 = n_out;
    idle(12, 1'b0);
    chk("ovfl_drain_count", n_out - out0, 8);
    chk("ovfl_drained", exp_q.size(), 0);
    chk("ovfl_sticky", ovfl, 1'b1);

    // Atomic pair while stall toggles every other cycle.
    for (int k = 0; k < 10; k++) begin
      cyc(k < 2, k == 0, (k == 0) ? 124'hA1 : 124'hA2, k[0], 1'b1, 1'b0);
      if (k == 3) begin
        chk("atm_stall_rdy",  buf_rdy,  1'b0);
        chk("atm_stall_atm",  buf_atm,  1'b1);
        chk("atm_stall_data", buf_data, 124'hA1);
      end
      if (k == 4) chk("atm_pop1_data", buf_data, 124'hA1);
      if (k == 5) begin
        chk("atm_stall2_rdy", buf_rdy, 1'b0);
        chk("atm_stall2_atm", buf_atm, 1'b0);
        chk("atm_stall2_data", buf_data, 124'hA2);
      end
      if (k == 6) chk("atm_pop2_rdy", buf_rdy, 1'b1);
    end
    chk("atm_drained", exp_q.size(), 0);

    // Reset pulse with 5 entries buffered.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 124'h3000 + W'(k), 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    chk("pre_rst_head", buf_data, 124'h3000);
    chk("pre_rst_stall", buf_stall, 1'b1);
    #1;
    sc_stall = 1'b0;
    arst_l = 1'b0;
    #1;
    chk("mid_rst_rdy",   buf_rdy,   1'b0);
    chk("mid_rst_atm",   buf_atm,   1'b0);
    chk("mid_rst_data",  buf_data,  '0);
    chk("mid_rst_stall", buf_stall, 1'b0);
    chk("mid_rst_ovfl",  ovfl,      1'b0);
    #9 arst_l = 1'b1;
    exp_q.delete(); in_q.delete();
    for (int k = 0; k < 10; k++) begin
      idle(1, 1'b0);
      chk("post_rst_quiet", buf_rdy, 1'b0);
    end

`ifdef SCTAG_PCX_RPTR_PAR_EN
    sb_en = 0;
    cyc(1'b1, 1'b0, 124'h5A5, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("par_err_clean", par_err, 1'b0);
    dut.u_skid.mem[0][3] = ~dut.u_skid.mem[0][3];
    idle(2, 1'b0);
    chk("par_err_set", par_err, 1'b1);
    sb_en = 1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sctag_pcx_rptr_pipe.md
Name: sctag_pcx_rptr_pipe

Overview:
- Parametrised, flopped successor to the combinational PCX→SCTAG repeater.
- Carries the PCX packet forward (data_rdy, atm, data) through STAGES register stages.
- Carries the SCTAG stall back through STAGES register stages.
- An output skid FIFO absorbs packets still in flight when stall is raised, so nothing is dropped across long wires.

Parameters:
- WIDTH, 124, PCX packet width in bits.
- STAGES, 2, forward and return pipeline depth; legal range 1..4.
- DEPTH (localparam), 2*STAGES+4, skid FIFO entries.

Ports:
- rclk  in  1  clock.
- arst_l  in  1  reset, asynchronous, active-low.
- pcx_sctag_data_rdy_px1  in  1  packet valid from PCX.
- pcx_sctag_atm_px1  in  1  packet is first of an atomic pair.
- pcx_sctag_data_px2  in  WIDTH  packet payload.
- sctag_pcx_stall_pq  in  1  SCTAG cannot accept a packet this cycle.
- pcx_sctag_data_rdy_buf  out  1  packet valid toward SCTAG.
- pcx_sctag_atm_buf  out  1  atm toward SCTAG.
- pcx_sctag_data_buf  out  WIDTH  payload toward SCTAG.
- sctag_pcx_stall_pq_buf  out  1  delayed stall toward PCX.
- rptr_ovfl  out  1  sticky: FIFO write while full.

Behaviour:
- Reset (arst_l low, async): all pipeline flops, FIFO pointers and count, rptr_ovfl and sctag_pcx_stall_pq_buf clear to 0. All outputs are 0 while in reset and on the first edge after release.
- Forward path: {rdy, atm, data} is registered STAGES times.
  - Stage data flops load only when the incoming rdy=1; rdy itself loads every cycle. Payload is therefore don't-care when rdy=0.
  - Stage-STAGES rdy=1 pushes {atm, data} into the FIFO.
- FIFO: DEPTH entries, binary wr/rd pointers wrap at DEPTH; count_q ranges 0..DEPTH.
  - Output is combinational from the FIFO head.
  - pcx_sctag_data_rdy_buf = (count_q != 0) & ~sctag_pcx_stall_pq. atm/data show the head entry, held stable while stalled.
  - Pop occurs when pcx_sctag_data_rdy_buf = 1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Empty FIFO: push becomes visible at the head the next cycle. There is no same-cycle bypass.
  - Total forward latency with an empty FIFO and no stall: STAGES+1 cycles from input rdy to output rdy.
- Stall return:
  - stall_raw = (count_q >= DEPTH-2*STAGES-1), i.e. count_q >= 3.
  - stall_raw is registered STAGES times to drive sctag_pcx_stall_pq_buf.
  - PCX honours it from the following cycle. The threshold guarantees at most DEPTH entries even with zero pops.
- Push while count_q==DEPTH and no pop:
  - Write is suppressed; the head is preserved.
  - rptr_ovfl sets and holds until reset.
  - The simulation assertion fires.
- Atomic pairs are transported as two ordinary packets. No pair-splitting logic is required: SCTAG stall handles pairs.
- Reset mid-operation: all in-flight and buffered packets are discarded. No partial output is permitted.

Optional Feature:
- Macro: SCTAG_PCX_RPTR_PAR_EN.
- Defined:
  - Even parity over {atm, data} is generated at input stage 1 and carried as an extra FIFO bit.
  - Parity is checked on each pop.
  - A mismatch sets a sticky output port rptr_par_err (reset 0).
- Undefined: the port, the parity bit and the checker are absent. Behaviour is otherwise identical.

Decomposition:
- Package sctag_pcx_rptr_pkg:
  - PCX_WIDTH_DEF = 124.
  - MAX_STAGES = 4.
  - Function rptr_depth(stages) = 2*stages+4.
  - Function rptr_stall_thr(stages) = rptr_depth(stages)-2*stages-1.
- Sub-module sctag_pcx_rptr_skid: generic DEPTH×W FIFO with count, full/empty and ovfl. The top instantiates one FIFO plus the two pipeline chains.

Test Plan:
- Single packet, STAGES=2: rdy=1, data=124'h0A5 at cycle 10, stall=0 → output rdy=1, data=124'h0A5 at cycle 13, count returns to 0.
- Back-to-back stream of 20 packets with no stall → 20 outputs in order, one per cycle, each 3 cycles after its input; sctag_pcx_stall_pq_buf never asserts.
- Stall held while streaming, with PCX honouring stall_buf (STAGES=2, DEPTH=8):
  - Stall raised continuously → count peaks ≤ 8, rptr_ovfl stays 0, stall_buf rises 2 cycles after count hits 3.
  - After stall is dropped, all packets drain in order.
- Misbehaving PCX ignores stall_buf with SCTAG stalled for 12 cycles → rptr_ovfl=1 after the 9th push; entries 1–8 are delivered intact once stall drops.
- Atomic pair with atm=1,0 arriving while stall toggles every other cycle → both packets delivered in order, atm bits preserved, head data stable during stall.
- Reset pulse (arst_l low 1 cycle, asynchronous mid-cycle) with 5 entries buffered → all outputs 0 immediately; no packet emerges afterward. With SCTAG_PCX_RPTR_PAR_EN, a forced FIFO bit flip sets rptr_par_err on that pop.
